// File: rtl/mutation_unit_if.sv
// rtl/mutation_unit_if.sv - handshake and generator bundle for the mutation stage
//
// Signals:
//   rate       mutation threshold, sampled at accept
//   in_valid / in_ready / in_data      chromosome input handshake
//   random / rand_ce                   generator word and its clock-enable
//   out_valid / out_ready / out_data / mutations   result handshake
// Modports:
//   slave  - the mutation stage itself
//   master - the surrounding datapath (generator, producer, consumer)
interface mutation_unit_if #(
    parameter int Width           = 8,
    parameter int ChromosomeWidth = 16,
    parameter int RateWidth       = 8,
    parameter int CountWidth      = $clog2(ChromosomeWidth + 1)
);
    logic [RateWidth-1:0]       rate;
    logic                       in_valid;
    logic                       in_ready;
    logic [ChromosomeWidth-1:0] in_data;
    logic [Width-1:0]           random;
    logic                       rand_ce;
    logic                       out_valid;
    logic                       out_ready;
    logic [ChromosomeWidth-1:0] out_data;
    logic [CountWidth-1:0]      mutations;

    modport slave (
        input  rate, in_valid, in_data, random, out_ready,
        output in_ready, rand_ce, out_valid, out_data, mutations
    );

    modport master (
        output rate, in_valid, in_data, random, out_ready,
        input  in_ready, rand_ce, out_valid, out_data, mutations
    );
endinterface

// File: rtl/mutation_unit.sv
// rtl/mutation_unit.sv - bit-flip mutation stage driven by an external random word
//
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  mutation_unit_if.slave: chromosome in, random word / rand_ce,
//        mutated chromosome and flip count out
//
// One chromosome is accepted in IDLE, its genes are walked one per cycle in
// MUTATE (one random word consumed per gene), and the result is held in DONE
// until the consumer takes it.
module mutation_unit #(
    parameter int Width           = 8,
    parameter int ChromosomeWidth = 16,
    parameter int RateWidth       = 8,
    parameter int CountWidth      = $clog2(ChromosomeWidth + 1)
) (
    input  logic            clk,
    input  logic            rst,
    mutation_unit_if.slave  bus
);
    localparam int IdxWidth = $clog2(ChromosomeWidth);
    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(ChromosomeWidth - 1);

    if (ChromosomeWidth < 2) begin : g_bad_chromosome_width
        $error("mutation_unit: ChromosomeWidth must be at least 2");
    end
    if (RateWidth > Width) begin : g_bad_rate_width
        $error("mutation_unit: RateWidth must not exceed Width");
    end

    typedef enum logic [1:0] {
        IDLE,
        MUTATE,
        DONE
    } state_t;

    state_t                     state_q;
    state_t                     state_d;
    logic [ChromosomeWidth-1:0] work_q;
    logic [RateWidth-1:0]       rate_q;
    logic [IdxWidth-1:0]        idx_q;
    logic [CountWidth-1:0]      cnt_q;

    logic accept;
    logic flip;

    assign accept = (state_q == IDLE) && bus.in_valid;
    // Only the low RateWidth bits of the generator word take part in the compare.
    assign flip   = (bus.random[RateWidth-1:0] < rate_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.rand_ce   = 1'b0;
        bus.out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_d = MUTATE;
                end
            end
            MUTATE: begin
                bus.rand_ce = 1'b1;
                if (idx_q == LastIdx) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath: rate is captured at accept so later changes cannot affect the
    // chromosome in flight. Result registers are left untouched after the
    // output handshake so out_data/mutations hold until the next accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work_q <= '0;
            rate_q <= '0;
            idx_q  <= '0;
            cnt_q  <= '0;
        end else if (accept) begin
            work_q <= bus.in_data;
            rate_q <= bus.rate;
            idx_q  <= '0;
            cnt_q  <= '0;
        end else if (state_q == MUTATE) begin
            if (flip) begin
                work_q[idx_q] <= ~work_q[idx_q];
                cnt_q         <= cnt_q + CountWidth'(1);
            end
            if (idx_q != LastIdx) begin
                idx_q <= idx_q + IdxWidth'(1);
            end
        end
    end

    assign bus.out_data  = work_q;
    assign bus.mutations = cnt_q;
endmodule

// File: tb/tb_mutation_unit.sv
// tb/tb_mutation_unit.sv - directed self-checking bench for mutation_unit
module tb_mutation_unit;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    mutation_unit_if #(.Width(8), .ChromosomeWidth(16), .RateWidth(8)) bus ();

    mutation_unit #(.Width(8), .ChromosomeWidth(16), .RateWidth(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; offers one chromosome, drives one random word
    // per gene, checks latency, result, optional stall, and the handshake.
    // Returns at the falling edge right after the output handshake.
    task automatic run_chrom(input string tag, input logic [15:0] data, input logic [7:0] r,
                             input logic [7:0] rnd_even, input logic [7:0] rnd_odd,
                             input int stall, input bit hold_valid, input int rate_chg_at,
                             input logic [15:0] exp_data, input logic [4:0] exp_mut);
        int ce_cycles;
        bit early_valid;
        ce_cycles   = 0;
        early_valid = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = data;
        bus.rate      = r;
        bus.out_ready = 1'b0;
        check_eq({tag, " in_ready before accept"}, 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (!hold_valid) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 16'hDEAD;
            end
            if (i == rate_chg_at) bus.rate = 8'h00;
            bus.random  = (i % 2 == 0) ? rnd_even : rnd_odd;
            ce_cycles  += int'(bus.rand_ce);
            early_valid = early_valid | bus.out_valid;
            if (i == 0) check_eq({tag, " in_ready in mutate"}, 32'(bus.in_ready), 32'd0);
        end
        @(negedge clk);
        bus.random = 8'h00;
        check_eq({tag, " rand_ce cycles"}, 32'(ce_cycles), 32'd16);
        check_eq({tag, " out_valid early"}, 32'(early_valid), 32'd0);
        check_eq({tag, " out_valid at latency"}, 32'(bus.out_valid), 32'd1);
        check_eq({tag, " rand_ce in done"}, 32'(bus.rand_ce), 32'd0);
        check_eq({tag, " out_data"}, 32'(bus.out_data), 32'(exp_data));
        check_eq({tag, " mutations"}, 32'(bus.mutations), 32'(exp_mut));
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            check_eq({tag, " stall out_valid"}, 32'(bus.out_valid), 32'd1);
            check_eq({tag, " stall out_data"}, 32'(bus.out_data), 32'(exp_data));
            check_eq({tag, " stall mutations"}, 32'(bus.mutations), 32'(exp_mut));
            check_eq({tag, " stall in_ready"}, 32'(bus.in_ready), 32'd0);
            check_eq({tag, " stall rand_ce"}, 32'(bus.rand_ce), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check_eq({tag, " out_valid after handshake"}, 32'(bus.out_valid), 32'd0);
        check_eq({tag, " in_ready after handshake"}, 32'(bus.in_ready), 32'd1);
        check_eq({tag, " out_data held"}, 32'(bus.out_data), 32'(exp_data));
        check_eq({tag, " mutations held"}, 32'(bus.mutations), 32'(exp_mut));
        if (!hold_valid) bus.in_valid = 1'b0;
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.rate      = 8'h00;
        bus.in_valid  = 1'b0;
        bus.in_data   = 16'h0000;
        bus.random    = 8'h00;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("reset in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("reset out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("reset rand_ce", 32'(bus.rand_ce), 32'd0);
        check_eq("reset out_data", 32'(bus.out_data), 32'd0);
        check_eq("reset mutations", 32'(bus.mutations), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("post-reset in_ready", 32'(bus.in_ready), 32'd1);

        run_chrom("rate0", 16'hA5A5, 8'h00, 8'h00, 8'h00, 0, 1'b0, -1, 16'hA5A5, 5'd0);
        run_chrom("allflip", 16'hA5A5, 8'h01, 8'h00, 8'h00, 0, 1'b0, -1, 16'h5A5A, 5'd16);
        run_chrom("alt80", 16'h0000, 8'h80, 8'h00, 8'hFF, 0, 1'b0, -1, 16'h5555, 5'd8);
        run_chrom("altFF", 16'h0000, 8'hFF, 8'h00, 8'hFF, 0, 1'b0, -1, 16'h5555, 5'd8);
        run_chrom("stall", 16'h00FF, 8'h01, 8'h00, 8'h00, 5, 1'b1, -1, 16'hFF00, 5'd16);
        run_chrom("b2b", 16'h1234, 8'h00, 8'h00, 8'h00, 0, 1'b0, -1, 16'h1234, 5'd0);
        run_chrom("ratechg", 16'hA5A5, 8'h01, 8'h00, 8'h00, 0, 1'b0, 4, 16'h5A5A, 5'd16);

        // Reset in the middle of MUTATE, during the gene-7 cycle.
        bus.in_valid = 1'b1;
        bus.in_data  = 16'hFFFF;
        bus.rate     = 8'h01;
        bus.random   = 8'h00;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
        check_eq("pre-reset rand_ce", 32'(bus.rand_ce), 32'd1);
        rst = 1'b1;
        #1;
        check_eq("midrst out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("midrst rand_ce", 32'(bus.rand_ce), 32'd0);
        check_eq("midrst in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("midrst out_data", 32'(bus.out_data), 32'd0);
        check_eq("midrst mutations", 32'(bus.mutations), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("after midrst in_ready", 32'(bus.in_ready), 32'd1);
        check_eq("after midrst rand_ce", 32'(bus.rand_ce), 32'd0);
        run_chrom("postrst", 16'h0F0F, 8'h80, 8'h00, 8'hFF, 0, 1'b0, -1, 16'h5A5A, 5'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
